// File: rtl/m92_region_loader.sv
// m92_region_loader
//   Parses the ROM download byte stream into per-region writes. Every region
//   begins with a 4-byte big-endian byte count followed by that many data
//   bytes. SDRAM regions are written at base_addr + dest, where dest applies an
//   optional N-lane interleave. Regions with a non-zero bram_cs go to on-chip
//   BRAM instead.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   ioctl_download       high while the stream runs; rising edge restarts parsing
//   ioctl_wr/ioctl_dout  one-cycle byte strobe and byte
//   ioctl_wait           backpressure, high while an SDRAM write is pending
//   sdr_req/sdr_ack      level request held until the one-cycle acknowledge
//   sdr_addr/data/be     SDRAM byte address, duplicated byte, lane enable
//   bram_cs/addr/data    one-cycle BRAM write pulse (offset within region)
//   region_idx           region currently being parsed
//   done, error          sticky status flags, cleared by a new download

package m92_pkg;
  typedef struct packed {
    logic [24:0] base_addr;
    logic [1:0]  ilv;
    logic [4:0]  bram_cs;
  } region_v2_t;

  // Default M92 layout. Index 0 is the rightmost entry.
  localparam region_v2_t [7:0] LOAD_REGIONS_V2 = {
    region_v2_t'{base_addr: 25'h0000000, ilv: 2'd0, bram_cs: 5'b00100},
    region_v2_t'{base_addr: 25'h0000000, ilv: 2'd0, bram_cs: 5'b00010},
    region_v2_t'{base_addr: 25'h0000000, ilv: 2'd0, bram_cs: 5'b00001},
    region_v2_t'{base_addr: 25'h0800000, ilv: 2'd0, bram_cs: 5'b00000},
    region_v2_t'{base_addr: 25'h0400000, ilv: 2'd2, bram_cs: 5'b00000},
    region_v2_t'{base_addr: 25'h0200000, ilv: 2'd1, bram_cs: 5'b00000},
    region_v2_t'{base_addr: 25'h0100000, ilv: 2'd0, bram_cs: 5'b00000},
    region_v2_t'{base_addr: 25'h0000000, ilv: 2'd0, bram_cs: 5'b00000}
  };
endpackage

module m92_region_loader #(
  parameter int NUM_REGIONS = 8,
  parameter m92_pkg::region_v2_t [NUM_REGIONS-1:0] REGIONS = m92_pkg::LOAD_REGIONS_V2,
  parameter int LANE_BYTES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        sdr_req,
  input  logic        sdr_ack,
  output logic [24:0] sdr_addr,
  output logic [15:0] sdr_data,
  output logic [1:0]  sdr_be,
  output logic [4:0]  bram_cs,
  output logic [24:0] bram_addr,
  output logic [7:0]  bram_data,
  output logic [3:0]  region_idx,
  output logic        done,
  output logic        error
);

  localparam int LB = $clog2(LANE_BYTES);
  localparam logic [31:0] LANE_MASK = 32'(LANE_BYTES - 1);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_SDR_WAIT, S_DONE} state_t;

  state_t      state_q;
  logic [1:0]  hdr_cnt_q;
  logic [31:0] size_q;
  logic [31:0] offset_q;
  logic [1:0]  ilv_q;
  logic [5:0]  lg_q;
  logic        last_q;
  logic        restart_pend_q;
  logic        dl_q;
  logic        wait_q;
  logic        sdr_req_q;
  logic [24:0] sdr_addr_q;
  logic [7:0]  sdr_byte_q;
  logic [1:0]  sdr_be_q;
  logic [4:0]  bram_cs_q;
  logic [24:0] bram_addr_q;
  logic [7:0]  bram_data_q;
  logic [3:0]  region_idx_q;
  logic        done_q;
  logic        error_q;

  // Region table padded to 16 entries so region_idx can index it directly.
  m92_pkg::region_v2_t cfg_tab [16];
  m92_pkg::region_v2_t cfg;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cfg
      if (gi < NUM_REGIONS) begin : g_used
        assign cfg_tab[gi] = REGIONS[gi];
      end else begin : g_unused
        assign cfg_tab[gi] = '0;
      end
    end
  endgenerate

  assign cfg = cfg_tab[region_idx_q];

  logic        wr_ok;
  logic        dl_rise;
  logic        dl_fall;
  logic        last_region;
  logic [31:0] hdr_size_d;
  logic [31:0] offset_d;
  logic        region_end_d;
  logic [5:0]  log2_d;
  logic        is_pow2_d;
  logic        size_ok_d;
  logic [31:0] mask_d;
  logic [31:0] w_d;
  logic [31:0] k_d;
  logic [31:0] dest_d;
  logic [31:0] addr_sum_d;
  logic        restart_now;
  state_t      adv_state_d;
  logic [3:0]  adv_idx_d;
  logic        unused_addr_bits;

  assign wr_ok        = ioctl_wr & ioctl_download;
  assign dl_rise      = ioctl_download & ~dl_q;
  assign dl_fall      = ~ioctl_download & dl_q;
  assign last_region  = (region_idx_q == 4'(NUM_REGIONS - 1));
  assign hdr_size_d   = {size_q[23:0], ioctl_dout};
  assign offset_d     = offset_q + 32'd1;
  assign region_end_d = (offset_d == size_q);
  assign adv_state_d  = last_region ? S_DONE : S_HDR;
  assign adv_idx_d    = last_region ? region_idx_q : region_idx_q + 4'd1;

  // Highest set bit of the incoming size; exact log2 when it is a power of two.
  always_comb begin
    log2_d = '0;
    for (int i = 0; i < 32; i++) begin
      if (hdr_size_d[i]) log2_d = 6'(i);
    end
  end

  assign is_pow2_d = (hdr_size_d != 32'd0) && ((hdr_size_d & (hdr_size_d - 32'd1)) == 32'd0);
  assign size_ok_d = (cfg.ilv == 2'd0) ||
                     (is_pow2_d && (hdr_size_d >= (32'(LANE_BYTES) << cfg.ilv)));

  // Sub-image k occupies lane k of every group of L lanes. Because sizes are
  // powers of two, division and modulo collapse to shifts and masks.
  always_comb begin
    mask_d = (32'd1 << lg_q) - 32'd1;
    w_d    = offset_q & mask_d;
    k_d    = offset_q >> lg_q;
    if (ilv_q == 2'd0) begin
      dest_d = offset_q;
    end else begin
      dest_d = ((((w_d >> LB) << ilv_q) | k_d) << LB) | (w_d & LANE_MASK);
    end
  end

  assign addr_sum_d       = 32'(cfg.base_addr) + dest_d;
  assign unused_addr_bits = ^addr_sum_d[31:25];

  // A restart is deferred while an SDRAM write is outstanding and taken on its ack.
  assign restart_now = (state_q == S_SDR_WAIT) ? (sdr_ack & (restart_pend_q | dl_rise))
                                               : dl_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_HDR;
      hdr_cnt_q      <= '0;
      size_q         <= '0;
      offset_q       <= '0;
      ilv_q          <= '0;
      lg_q           <= '0;
      last_q         <= 1'b0;
      restart_pend_q <= 1'b0;
      dl_q           <= 1'b0;
      wait_q         <= 1'b0;
      sdr_req_q      <= 1'b0;
      sdr_addr_q     <= '0;
      sdr_byte_q     <= '0;
      sdr_be_q       <= '0;
      bram_cs_q      <= '0;
      bram_addr_q    <= '0;
      bram_data_q    <= '0;
      region_idx_q   <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      bram_cs_q <= '0;

      if (dl_fall && state_q != S_DONE) error_q <= 1'b1;

      case (state_q)
        S_HDR: begin
          if (wr_ok) begin
            size_q    <= hdr_size_d;
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'd3) begin
              if (hdr_size_d == 32'd0) begin
                state_q      <= adv_state_d;
                region_idx_q <= adv_idx_d;
                done_q       <= last_region;
              end else begin
                state_q  <= S_DATA;
                offset_q <= '0;
                if (size_ok_d) begin
                  ilv_q <= cfg.ilv;
                  lg_q  <= log2_d - {4'd0, cfg.ilv};
                end else begin
                  // Bad interleaved size: flag it and load the region linearly.
                  error_q <= 1'b1;
                  ilv_q   <= 2'd0;
                  lg_q    <= '0;
                end
              end
            end
          end
        end

        S_DATA: begin
          if (wr_ok) begin
            offset_q <= offset_d;
            if (cfg.bram_cs != 5'd0) begin
              bram_cs_q   <= cfg.bram_cs;
              bram_addr_q <= offset_q[24:0];
              bram_data_q <= ioctl_dout;
              if (region_end_d) begin
                state_q      <= adv_state_d;
                region_idx_q <= adv_idx_d;
                done_q       <= last_region;
              end
            end else begin
              sdr_req_q  <= 1'b1;
              wait_q     <= 1'b1;
              sdr_addr_q <= addr_sum_d[24:0];
              sdr_byte_q <= ioctl_dout;
              sdr_be_q   <= addr_sum_d[0] ? 2'b10 : 2'b01;
              last_q     <= region_end_d;
              state_q    <= S_SDR_WAIT;
            end
          end
        end

        S_SDR_WAIT: begin
          // Bytes offered while stalled are lost.
          if (ioctl_wr) error_q <= 1'b1;
          if (dl_rise) restart_pend_q <= 1'b1;
          if (sdr_ack) begin
            sdr_req_q <= 1'b0;
            wait_q    <= 1'b0;
            if (last_q) begin
              state_q      <= adv_state_d;
              region_idx_q <= adv_idx_d;
              done_q       <= last_region;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        default: ;
      endcase

      if (restart_now) begin
        state_q        <= S_HDR;
        hdr_cnt_q      <= '0;
        size_q         <= '0;
        offset_q       <= '0;
        ilv_q          <= '0;
        lg_q           <= '0;
        last_q         <= 1'b0;
        restart_pend_q <= 1'b0;
        region_idx_q   <= '0;
        done_q         <= 1'b0;
        error_q        <= 1'b0;
      end
    end
  end

  assign ioctl_wait = wait_q;
  assign sdr_req    = sdr_req_q;
  assign sdr_addr   = sdr_addr_q;
  assign sdr_data   = {sdr_byte_q, sdr_byte_q};
  assign sdr_be     = sdr_be_q;
  assign bram_cs    = bram_cs_q;
  assign bram_addr  = bram_addr_q;
  assign bram_data  = bram_data_q;
  assign region_idx = region_idx_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_m92_region_loader.sv
// Testbench for m92_region_loader: drives header/data byte streams, acknowledges
// SDRAM requests two cycles after they appear, and scores every SDRAM and BRAM
// write against a queue of expected writes built from the interleave formula.

module tb_m92_region_loader;

  localparam int NREG = 5;
  localparam int LANE = 2;
  localparam int K_SDR  = 0;
  localparam int K_BRAM = 1;
  localparam int K_NONE = 2;

  localparam m92_pkg::region_v2_t R0 = '{base_addr: 25'h0000000, ilv: 2'd0, bram_cs: 5'b00000};
  localparam m92_pkg::region_v2_t R1 = '{base_addr: 25'h0400000, ilv: 2'd2, bram_cs: 5'b00000};
  localparam m92_pkg::region_v2_t R2 = '{base_addr: 25'h0000000, ilv: 2'd0, bram_cs: 5'b00010};
  localparam m92_pkg::region_v2_t R3 = '{base_addr: 25'h0100000, ilv: 2'd0, bram_cs: 5'b00000};
  localparam m92_pkg::region_v2_t R4 = '{base_addr: 25'h0200000, ilv: 2'd2, bram_cs: 5'b00000};
  localparam m92_pkg::region_v2_t [NREG-1:0] TB_REGIONS = {R4, R3, R2, R1, R0};

  logic        clk;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        sdr_req;
  logic        sdr_ack;
  logic [24:0] sdr_addr;
  logic [15:0] sdr_data;
  logic [1:0]  sdr_be;
  logic [4:0]  bram_cs;
  logic [24:0] bram_addr;
  logic [7:0]  bram_data;
  logic [3:0]  region_idx;
  logic        done;
  logic        error;

  m92_region_loader #(
    .NUM_REGIONS(NREG),
    .REGIONS(TB_REGIONS),
    .LANE_BYTES(LANE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .sdr_req(sdr_req),
    .sdr_ack(sdr_ack),
    .sdr_addr(sdr_addr),
    .sdr_data(sdr_data),
    .sdr_be(sdr_be),
    .bram_cs(bram_cs),
    .bram_addr(bram_addr),
    .bram_data(bram_data),
    .region_idx(region_idx),
    .done(done),
    .error(error)
  );

  typedef struct {
    logic        is_bram;
    logic [4:0]  cs;
    logic [24:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  logic ack_busy = 1'b0;
  int   ack_cnt  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected interleave destination, straight from the division/modulo formula.
  function automatic logic [24:0] dmodel(input int off, input int size, input int ilv);
    int l;
    int sub;
    int k;
    int w;
    l   = 1 << ilv;
    sub = size / l;
    k   = off / sub;
    w   = off % sub;
    return 25'(((w / LANE) * l + k) * LANE + (w % LANE));
  endfunction

  task automatic push_sdr(input logic [24:0] a, input logic [7:0] d);
    wr_t e;
    e.is_bram = 1'b0;
    e.cs      = 5'd0;
    e.addr    = a;
    e.data    = d;
    exp_q.push_back(e);
  endtask

  task automatic push_bram(input logic [4:0] cs, input logic [24:0] a, input logic [7:0] d);
    wr_t e;
    e.is_bram = 1'b1;
    e.cs      = cs;
    e.addr    = a;
    e.data    = d;
    exp_q.push_back(e);
  endtask

  // SDRAM arbiter model: score the request, ack it two cycles later.
  initial begin
    sdr_ack = 1'b0;
    forever begin
      @(negedge clk);
      sdr_ack = 1'b0;
      if (ack_busy) begin
        chk("req_hold", 32'(sdr_req), 32'd1);
        chk("wait_hold", 32'(ioctl_wait), 32'd1);
        ack_cnt++;
        if (ack_cnt == 2) begin
          sdr_ack  = 1'b1;
          ack_busy = 1'b0;
        end
      end else if (sdr_req) begin
        wr_t e;
        $display("sdr  addr=%h data=%h be=%b", sdr_addr, sdr_data, sdr_be);
        chk("sdr_queue", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sdr_kind", 32'(e.is_bram), 32'd0);
          chk("sdr_addr", 32'(sdr_addr), 32'(e.addr));
          chk("sdr_data", 32'(sdr_data), 32'({e.data, e.data}));
          chk("sdr_be", 32'(sdr_be), e.addr[0] ? 32'd2 : 32'd1);
        end
        ack_busy = 1'b1;
        ack_cnt  = 0;
      end
    end
  end

  // BRAM write monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (bram_cs != 5'd0) begin
        wr_t e;
        $display("bram cs=%b addr=%h data=%h", bram_cs, bram_addr, bram_data);
        chk("bram_queue", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bram_kind", 32'(e.is_bram), 32'd1);
          chk("bram_cs", 32'(bram_cs), 32'(e.cs));
          chk("bram_addr", 32'(bram_addr), 32'(e.addr));
          chk("bram_data", 32'(bram_data), 32'(e.data));
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int kind, input logic junk);
    @(negedge clk);
    ioctl_wr   = 1'b1;
    ioctl_dout = b;
    @(negedge clk);
    ioctl_wr = 1'b0;
    case (kind)
      K_SDR: begin
        chk("req_next", 32'(sdr_req), 32'd1);
        chk("wait_next", 32'(ioctl_wait), 32'd1);
      end
      K_BRAM: begin
        chk("bram_next", 32'(bram_cs != 5'd0), 32'd1);
        chk("wait_bram", 32'(ioctl_wait), 32'd0);
      end
      default: chk("idle_req", 32'(sdr_req), 32'd0);
    endcase
    if (junk) begin
      ioctl_wr   = 1'b1;
      ioctl_dout = 8'hEE;
      @(negedge clk);
      ioctl_wr = 1'b0;
    end
    for (int t = 0; t < 40 && ioctl_wait; t++) @(negedge clk);
    chk("wait_release", 32'(ioctl_wait), 32'd0);
    chk("req_release", 32'(sdr_req), 32'd0);
  endtask

  task automatic send_hdr(input logic [31:0] size);
    logic [31:0] s;
    s = size;
    for (int i = 3; i >= 0; i--) send(s[i*8 +: 8], K_NONE, 1'b0);
  endtask

  task automatic restart_download();
    @(negedge clk);
    ioctl_download = 1'b0;
    @(negedge clk);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [4];
    t1[0] = 8'hAA; t1[1] = 8'hBB; t1[2] = 8'hCC; t1[3] = 8'hDD;

    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_dout     = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_flags", 32'({sdr_req, ioctl_wait, done, error, bram_cs, region_idx}), 32'd0);
    chk("rst_sdr_addr", 32'(sdr_addr), 32'd0);
    chk("rst_data", 32'({sdr_data, sdr_be, bram_data}), 32'd0);
    chk("rst_bram_addr", 32'(bram_addr), 32'd0);
    reset = 1'b0;

    // Download A: linear, sprite interleave, BRAM, empty region, small interleave.
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk);

    send_hdr(32'd4);
    for (int i = 0; i < 4; i++) begin
      push_sdr(25'(i), t1[i]);
      send(t1[i], K_SDR, 1'b0);
    end
    chk("idx_after_r0", 32'(region_idx), 32'd1);

    send_hdr(32'd16);
    for (int i = 0; i < 16; i++) begin
      push_sdr(25'h0400000 + dmodel(i, 16, 2), 8'(i));
      send(8'(i), K_SDR, 1'b0);
    end
    chk("idx_after_r1", 32'(region_idx), 32'd2);
    chk("err_after_r1", 32'(error), 32'd0);

    send_hdr(32'd3);
    for (int i = 0; i < 3; i++) begin
      push_bram(5'b00010, 25'(i), 8'h30 + 8'(i));
      send(8'h30 + 8'(i), K_BRAM, 1'b0);
    end
    chk("idx_after_r2", 32'(region_idx), 32'd3);

    send_hdr(32'd0);
    chk("idx_after_empty", 32'(region_idx), 32'd4);
    chk("queue_after_empty", 32'(exp_q.size()), 32'd0);

    send_hdr(32'd8);
    for (int i = 0; i < 8; i++) begin
      push_sdr(25'h0200000 + dmodel(i, 8, 2), 8'h60 + 8'(i));
      send(8'h60 + 8'(i), K_SDR, 1'b0);
    end
    chk("done_a", 32'(done), 32'd1);
    chk("idx_done_a", 32'(region_idx), 32'd4);
    send(8'h99, K_NONE, 1'b0);
    send(8'h9A, K_NONE, 1'b0);
    chk("err_done_ignore", 32'(error), 32'd0);
    chk("done_sticky", 32'(done), 32'd1);

    // Download B: byte pulsed during backpressure is dropped and flagged.
    restart_download();
    chk("done_cleared_b", 32'(done), 32'd0);
    chk("idx_restart_b", 32'(region_idx), 32'd0);
    send_hdr(32'd4);
    push_sdr(25'd0, 8'h11);
    send(8'h11, K_SDR, 1'b1);
    chk("err_overrun", 32'(error), 32'd1);
    push_sdr(25'd1, 8'h22);
    send(8'h22, K_SDR, 1'b0);
    push_sdr(25'd2, 8'h33);
    send(8'h33, K_SDR, 1'b0);
    push_sdr(25'd3, 8'h44);
    send(8'h44, K_SDR, 1'b0);
    chk("idx_after_overrun", 32'(region_idx), 32'd1);

    // Download C: error cleared; bad interleaved size loads linearly.
    restart_download();
    chk("err_cleared_c", 32'(error), 32'd0);
    for (int r = 0; r < 4; r++) send_hdr(32'd0);
    chk("idx_skip_c", 32'(region_idx), 32'd4);
    send_hdr(32'd12);
    chk("err_bad_size", 32'(error), 32'd1);
    for (int i = 0; i < 12; i++) begin
      push_sdr(25'h0200000 + 25'(i), 8'h80 + 8'(i));
      send(8'h80 + 8'(i), K_SDR, 1'b0);
    end
    chk("done_c", 32'(done), 32'd1);

    // Download D: stream ends after 2 of 4 data bytes.
    restart_download();
    chk("err_cleared_d", 32'(error), 32'd0);
    send_hdr(32'd4);
    push_sdr(25'd0, 8'hA1);
    send(8'hA1, K_SDR, 1'b0);
    push_sdr(25'd1, 8'hA2);
    send(8'hA2, K_SDR, 1'b0);
    @(negedge clk);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_short", 32'(error), 32'd1);
    chk("done_short", 32'(done), 32'd0);
    chk("queue_end", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
